// File: rtl/mapper_bus_replayer.sv
// mapper_bus_replayer
//
// Bus master for the mapper-side CPU bus. It replays a stream of register
// accesses (writes and reads) into the enabled mapper, e.g. for save-state
// restore or the mapper test harness. While a replay runs, the CPU is paused
// and the bus carries the replay registers. Otherwise the CPU bus passes
// straight through.
//
// Parameters:
//   GAP_CYCLES  idle ce slots inserted after every replayed access (0..3)
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   ce                         M2 strobe; mappers sample the bus when ce=1
//   cmd_valid/cmd_ready        command handshake
//   cmd_addr/cmd_data          access address / write data
//   cmd_read/cmd_last          1 = read access / final command of the replay
//   rsp_valid/rsp_data         one-clk pulse with captured read data
//   busy                       replay owns the bus
//   done                       one-clk pulse when the replay completes
//   cpu_pause                  stall request to the CPU core
//   cpu_ain/write/read/dout    CPU bus (pass-through source)
//   prg_ain/write/read/din     bus driven to the mapper
//   prg_dout                   mapper / PRG read data
module mapper_bus_replayer #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_read,
  input  logic        cmd_last,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        done,
  output logic        cpu_pause,
  input  logic [15:0] cpu_ain,
  input  logic        cpu_write,
  input  logic        cpu_read,
  input  logic [7:0]  cpu_dout,
  output logic [15:0] prg_ain,
  output logic        prg_write,
  output logic        prg_read,
  output logic [7:0]  prg_din,
  input  logic [7:0]  prg_dout
);

  typedef enum logic [2:0] {
    StIdle, StPause, StArm, StSlot, StGap, StFinish
  } state_e;

  // Value of the gap counter on the final idle ce edge.
  localparam logic [1:0] GapLast = (GAP_CYCLES == 0) ? 2'd0 : 2'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] ain_q, ain_d;
  logic [7:0]  din_q, din_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic        last_q, last_d;
  logic [1:0]  gap_q, gap_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;

  always_comb begin
    state_d     = state_q;
    ain_d       = ain_q;
    din_d       = din_q;
    write_d     = write_q;
    read_d      = read_q;
    last_d      = last_q;
    gap_d       = gap_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) state_d = StPause;
      end
      // The first ce edge seen here is the CPU's last bus slot.
      StPause: begin
        if (ce) begin
          state_d = StArm;
          ain_d   = '0;
          din_d   = '0;
          write_d = 1'b0;
          read_d  = 1'b0;
        end
      end
      StArm: begin
        if (cmd_valid) begin
          ain_d   = cmd_addr;
          din_d   = cmd_data;
          write_d = ~cmd_read;
          read_d  = cmd_read;
          last_d  = cmd_last;
          state_d = StSlot;
        end
      end
      // The mapper samples on this ce edge; strobes drop on the same edge,
      // the address is held through the gap.
      StSlot: begin
        if (ce) begin
          write_d = 1'b0;
          read_d  = 1'b0;
          gap_d   = 2'd0;
          if (read_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = prg_dout;
          end
          if (GAP_CYCLES == 0) state_d = last_q ? StFinish : StArm;
          else                 state_d = StGap;
        end
      end
      StGap: begin
        if (ce) begin
          if (gap_q == GapLast) state_d = last_q ? StFinish : StArm;
          else                  gap_d = gap_q + 2'd1;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ain_q       <= '0;
      din_q       <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      last_q      <= 1'b0;
      gap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ain_q       <= ain_d;
      din_q       <= din_d;
      write_q     <= write_d;
      read_q      <= read_d;
      last_q      <= last_d;
      gap_q       <= gap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    busy      = (state_q == StArm) || (state_q == StSlot) || (state_q == StGap);
    cpu_pause = busy || (state_q == StPause);
    cmd_ready = (state_q == StArm);
    done      = (state_q == StFinish);
    rsp_valid = rsp_valid_q;
    rsp_data  = rsp_data_q;
    // CPU strobes are ignored while the replay owns the bus.
    prg_ain   = busy ? ain_q   : cpu_ain;
    prg_write = busy ? write_q : cpu_write;
    prg_read  = busy ? read_q  : cpu_read;
    prg_din   = busy ? din_q   : cpu_dout;
  end

endmodule

// File: tb/tb_mapper_bus_replayer.sv
// Directed bench for mapper_bus_replayer. dut1 uses GAP_CYCLES=1, dut0 uses
// GAP_CYCLES=0. Small Mapper69 / Mapper67 register models observe the
// replayed writes.
module tb_mapper_bus_replayer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce = 1'b0;
  logic        cmd_valid0, cmd_valid1;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_read, cmd_last;
  logic [15:0] cpu_ain;
  logic        cpu_write, cpu_read;
  logic [7:0]  cpu_dout;
  logic [7:0]  prg_dout;

  logic        cmd_ready1, rsp_valid1, busy1, done1, cpu_pause1, prg_write1, prg_read1;
  logic [7:0]  rsp_data1, prg_din1;
  logic [15:0] prg_ain1;
  logic        cmd_ready0, rsp_valid0, busy0, done0, cpu_pause0, prg_write0, prg_read0;
  logic [7:0]  rsp_data0, prg_din0;
  logic [15:0] prg_ain0;

  int checks = 0;
  int errors = 0;

  // Scoreboard state, updated at clk edges.
  int wr1 = 0, idle1 = 0, rsp1 = 0, done1_cnt = 0;
  int wr0 = 0, done0_cnt = 0, nonconsec = 0, ce_idx = 0, last_ce0 = 0;
  logic [3:0]  m69_cmd = 4'h0;
  logic [5:0]  m69_bank0 = 6'h0;
  logic        m69_ram_en = 1'b0, m69_ram_sel = 1'b0;
  logic [15:0] m67_cnt = 16'h0;
  logic        m67_tog = 1'b0, m67_en = 1'b0;

  mapper_bus_replayer #(.GAP_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .ce(ce),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_read(cmd_read), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1), .done(done1),
    .cpu_pause(cpu_pause1), .cpu_ain(cpu_ain), .cpu_write(cpu_write),
    .cpu_read(cpu_read), .cpu_dout(cpu_dout), .prg_ain(prg_ain1),
    .prg_write(prg_write1), .prg_read(prg_read1), .prg_din(prg_din1),
    .prg_dout(prg_dout)
  );

  mapper_bus_replayer #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .ce(ce),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_read(cmd_read), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .busy(busy0), .done(done0),
    .cpu_pause(cpu_pause0), .cpu_ain(cpu_ain), .cpu_write(cpu_write),
    .cpu_read(cpu_read), .cpu_dout(cpu_dout), .prg_ain(prg_ain0),
    .prg_write(prg_write0), .prg_read(prg_read0), .prg_din(prg_din0),
    .prg_dout(prg_dout)
  );

  always #5 clk = ~clk;

  // ce is high on every third rising edge; it changes on falling edges.
  int ce_phase = 0;
  always @(negedge clk) begin
    ce_phase = (ce_phase == 2) ? 0 : ce_phase + 1;
    ce = (ce_phase == 2);
  end

  // PRG RAM returns $5A at $6004.
  assign prg_dout = (prg_read1 && prg_ain1 == 16'h6004) ? 8'h5A : 8'h00;

  always @(posedge clk) begin
    if (!reset) begin
      if (ce) ce_idx <= ce_idx + 1;
      if (ce && busy1 && prg_write1) begin
        wr1 <= wr1 + 1;
        if (prg_ain1[15:13] == 3'b100) m69_cmd <= prg_din1[3:0];
        else if (prg_ain1[15:13] == 3'b101 && m69_cmd == 4'h8) begin
          m69_bank0   <= prg_din1[5:0];
          m69_ram_sel <= prg_din1[6];
          m69_ram_en  <= prg_din1[7];
        end
      end
      if (ce && busy1 && !prg_write1 && !prg_read1 && wr1 == 1) idle1 <= idle1 + 1;
      if (rsp_valid1) rsp1 <= rsp1 + 1;
      if (done1) done1_cnt <= done1_cnt + 1;
      if (done0) done0_cnt <= done0_cnt + 1;
      if (ce && busy0 && prg_write0) begin
        if (wr0 > 0 && ce_idx != last_ce0 + 1) nonconsec <= nonconsec + 1;
        last_ce0 <= ce_idx;
        wr0 <= wr0 + 1;
        if (prg_ain0[15:11] == 5'b11001) begin
          if (!m67_tog) m67_cnt[15:8] <= prg_din0;
          else          m67_cnt[7:0]  <= prg_din0;
          m67_tog <= ~m67_tog;
        end else if (prg_ain0[15:11] == 5'b11011) begin
          m67_en  <= prg_din0[4];
          m67_tog <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int which, input logic [15:0] a, input logic [7:0] d,
                      input logic rd, input logic last);
    int n = 0;
    @(negedge clk);
    cmd_addr = a;
    cmd_data = d;
    cmd_read = rd;
    cmd_last = last;
    if (which == 0) cmd_valid0 = 1'b1;
    else            cmd_valid1 = 1'b1;
    while (!((which == 0) ? cmd_ready0 : cmd_ready1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
  endtask

  task automatic wait_done(input int which);
    int n = 0;
    while (!((which == 0) ? done0 : done1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_in_time", 32'(n < 300), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  int base, bad, n;

  initial begin
    reset = 1'b1;
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    cmd_read = 1'b0;
    cmd_last = 1'b0;
    cpu_ain = '0;
    cpu_write = 1'b0;
    cpu_read = 1'b0;
    cpu_dout = '0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_pause", 32'(cpu_pause1), 32'd0);
    check("rst_ready", 32'(cmd_ready1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("rst_rsp_data", 32'(rsp_data1), 32'd0);
    check("rst_busy0", 32'({busy0, cpu_pause0, cmd_ready0, rsp_valid0, rsp_data0}), 32'd0);
    reset = 1'b0;

    // Mapper69 bank write, GAP_CYCLES=1
    send(1, 16'h8000, 8'h08, 1'b0, 1'b0);
    send(1, 16'hA000, 8'hC3, 1'b0, 1'b1);
    wait_done(1);
    check("m69_writes", 32'(wr1), 32'd2);
    check("m69_idle_slots", 32'(idle1), 32'd1);
    check("m69_done_once", 32'(done1_cnt), 32'd1);
    check("m69_bank0", 32'(m69_bank0), 32'd3);
    check("m69_ram_en", 32'(m69_ram_en), 32'd1);
    check("m69_ram_sel", 32'(m69_ram_sel), 32'd1);
    check("busy_after_done", 32'({busy1, cpu_pause1}), 32'd0);

    // Read from PRG RAM
    base = wr1;
    send(1, 16'h6004, 8'h00, 1'b1, 1'b1);
    wait_done(1);
    check("read_rsp_pulses", 32'(rsp1), 32'd1);
    check("read_rsp_data", 32'(rsp_data1), 32'h5A);
    check("read_no_write", 32'(wr1), 32'(base));

    // Pass-through in IDLE
    @(negedge clk);
    cpu_ain = 16'hC000;
    cpu_dout = 8'h77;
    cpu_write = 1'b1;
    #1;
    check("pt_ain", 32'(prg_ain1), 32'hC000);
    check("pt_write", 32'(prg_write1), 32'd1);
    check("pt_din", 32'(prg_din1), 32'h77);

    // Back-pressure; CPU write stays high and must be ignored while busy
    base = wr1;
    send(1, 16'h8000, 8'h08, 1'b0, 1'b0);
    n = 0;
    while (!cmd_ready1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_rearm", 32'(cmd_ready1), 32'd1);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (!(busy1 && cpu_pause1 && !prg_write1 && !prg_read1)) bad++;
    end
    check("bp_hold", 32'(bad), 32'd0);
    check("bp_one_write", 32'(wr1), 32'(base + 1));
    send(1, 16'hA000, 8'h45, 1'b0, 1'b1);
    wait_done(1);
    check("bp_two_writes", 32'(wr1), 32'(base + 2));
    check("bp_bank0", 32'(m69_bank0), 32'd5);
    check("bp_ram", 32'({m69_ram_en, m69_ram_sel}), 32'b01);
    cpu_write = 1'b0;

    // Reset mid-replay (in SLOT)
    base = done1_cnt;
    send(1, 16'h8000, 8'h0F, 1'b0, 1'b0);
    check("slot_write_high", 32'(prg_write1), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rr_write", 32'(prg_write1), 32'd0);
    check("rr_busy", 32'(busy1), 32'd0);
    check("rr_pause", 32'(cpu_pause1), 32'd0);
    check("rr_done", 32'(done1), 32'd0);
    check("rr_ready", 32'(cmd_ready1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rr_no_done", 32'(done1_cnt), 32'(base));
    send(1, 16'h8000, 8'h08, 1'b0, 1'b0);
    send(1, 16'hA000, 8'h81, 1'b0, 1'b1);
    wait_done(1);
    check("rr_replay_done", 32'(done1_cnt), 32'(base + 1));
    check("rr_bank0", 32'(m69_bank0), 32'd1);
    check("rr_ram", 32'({m69_ram_en, m69_ram_sel}), 32'b10);

    // GAP_CYCLES=0, Mapper67 IRQ latch
    send(0, 16'hC800, 8'h12, 1'b0, 1'b0);
    send(0, 16'hC800, 8'h34, 1'b0, 1'b0);
    send(0, 16'hD800, 8'h10, 1'b0, 1'b1);
    wait_done(0);
    check("m67_writes", 32'(wr0), 32'd3);
    check("m67_consecutive", 32'(nonconsec), 32'd0);
    check("m67_counter", 32'(m67_cnt), 32'h1234);
    check("m67_enable", 32'(m67_en), 32'd1);
    check("m67_done_once", 32'(done0_cnt), 32'd1);
    check("m67_no_read", 32'({prg_read0, busy0}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mapper_bus_replayer.md
# mapper_bus_replayer

Bus master that drives the mapper-side CPU bus (`prg_ain`, `prg_write`, `prg_read`, `prg_din`) from a command stream instead of the 6502. It is the initiator for the register-write protocol every mapper module responds to. Save-state restore and the mapper test harness use it to replay register programming (bank selects, mirroring, IRQ latches, expansion-audio registers) into whichever mapper is enabled. While a replay is in progress it holds the CPU paused and owns the bus; otherwise it passes the CPU bus through unchanged.

## Interface
Parameters:
- `GAP_CYCLES`, default 1: number of idle M2 (`ce`) slots inserted after every replayed access, so the mapper sees no back-to-back strobes. Range 0–3.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `ce`  in  1  M2 strobe. Mappers sample the bus on `clk` edges where `ce`=1.
- `cmd_valid`  in  1  command available
- `cmd_ready`  out  1  command accepted on `clk` edge where `cmd_valid`&`cmd_ready`
- `cmd_addr`  in  16  CPU address
- `cmd_data`  in  8  write data, ignored for reads
- `cmd_read`  in  1  1 = read cycle, 0 = write cycle
- `cmd_last`  in  1  final command of the replay
- `rsp_valid`  out  1  one-`clk` pulse carrying read data
- `rsp_data`  out  8  data captured from `prg_dout`
- `busy`  out  1  replay owns the bus
- `done`  out  1  one-`clk` pulse after the last command's slot and gaps complete
- `cpu_pause`  out  1  stall request to the CPU core
- `cpu_ain`  in  16  CPU address (pass-through source)
- `cpu_write`  in  1  CPU write strobe
- `cpu_read`  in  1  CPU read strobe
- `cpu_dout`  in  8  CPU write data
- `prg_ain`  out  16  bus address to the mapper
- `prg_write`  out  1  bus write strobe
- `prg_read`  out  1  bus read strobe
- `prg_din`  out  8  bus write data
- `prg_dout`  in  8  mapper / PRG read data

## Operation
- States: IDLE, PAUSE, ARM, SLOT, GAP, FINISH.
- IDLE:
  - `busy`=0, `cpu_pause`=0, `cmd_ready`=0.
  - Bus outputs are combinationally equal to the `cpu_*` inputs.
  - `cmd_valid`=1 → PAUSE.
- PAUSE:
  - Assert `cpu_pause`.
  - Wait for the first `ce`=1 edge; that edge is the CPU's final bus slot.
  - Then set `busy`=1 and the bus mux selects replay registers → ARM.
  - Replay registers idle value: `prg_write`=0, `prg_read`=0, `prg_ain`=0, `prg_din`=0.
- ARM:
  - `cmd_ready`=1.
  - On accept, latch addr/data into `prg_ain`/`prg_din`, set `prg_write`=!`cmd_read`, `prg_read`=`cmd_read`, store `cmd_last` → SLOT.
  - Accept may occur on a `ce`=1 edge; the strobe is then first sampled at the following `ce` edge.
- SLOT:
  - `cmd_ready`=0; outputs held stable.
  - On the next `ce`=1 edge the mapper samples the access.
  - On that same edge: clear `prg_write`/`prg_read`, keep `prg_ain`. For reads, capture `prg_dout` into `rsp_data` and pulse `rsp_valid`.
  - Then → GAP, or, if `GAP_CYCLES`=0, → ARM (not last) / FINISH (last).
- GAP:
  - Count `GAP_CYCLES` `ce`=1 edges with strobes low.
  - Then → ARM if the stored last flag is 0, else FINISH.
- FINISH:
  - Pulse `done`; `busy`=0, `cpu_pause`=0; bus returns to pass-through → IDLE.
- Command acceptance:
  - Every accepted command produces exactly one strobed `ce` slot.
  - `cmd_valid` low in ARM simply waits with strobes low; the CPU stays paused.
- Replay writes are never blocked by address. The target mapper decides acceptance (ROM writes go to registers, `$6000–$7FFF` to PRG RAM).

## Timing
- Reset values: `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `done`=0, `cpu_pause`=0, replay registers 0, state IDLE.
- `reset` mid-replay:
  - Returns to IDLE on the next edge and drops all strobes immediately.
  - No `done` pulse; a partially applied replay is left as is.
- Throughput: one command per (1 + `GAP_CYCLES`) `ce` periods, plus up to one `ce` period of ARM latency.
- Read latency: `rsp_valid` on the same `clk` edge as the sampling `ce`.
- Strobes are never high for more than one `ce`=1 edge per command.
- `prg_ain`/`prg_din` change only on non-sampling edges or on the edge that ends a slot. They never change while a strobe is high.
- `cpu_pause` rises in PAUSE and falls the cycle FINISH is entered. CPU strobes arriving while `busy`=1 are ignored.
- `done` and `rsp_valid` are single-`clk` pulses.

## Test plan
- **Single write, Mapper69 (`GAP_CYCLES`=1):**
  - Stimulus: `cmd {$8000,$08,w}` then `cmd {$A000,$C3,w,last}`, `ce` every 3rd clk.
  - Required: mapper `prg_bank[0]`=3, `ram_enable`=1, `ram_select`=1.
  - Required: exactly 2 `prg_write` samples, 1 idle slot between them, `done` once.
- **Read:**
  - Stimulus: `cmd {$6004,read,last}` with `prg_dout`=$5A at the sampling edge.
  - Required: `rsp_valid` 1 clk, `rsp_data`=$5A, `prg_write` never 1.
- **Back-pressure:**
  - Stimulus: `cmd_valid` dropped for 10 `ce` periods between commands.
  - Required: `busy` and `cpu_pause` stay 1, strobes stay 0, no spurious write.
- **Pass-through:**
  - Stimulus: in IDLE, `cpu_write`=1, `cpu_ain`=$C000, `cpu_dout`=$77.
  - Required: `prg_ain`=$C000, `prg_write`=1, `prg_din`=$77 in the same cycle.
- **Reset mid-replay:**
  - Stimulus: reset asserted in SLOT.
  - Required: next cycle `prg_write`=0, `busy`=0, `cpu_pause`=0, `done`=0, state IDLE.
  - Required: a new replay then completes normally.
- **`GAP_CYCLES`=0, Mapper67 IRQ latch:**
  - Stimulus: writes `$C800`=$12, `$C800`=$34, `$D800`=$10 (last).
  - Required: consecutive-`ce` writes, `irq_counter`=$1234, `irq_enable`=1.
